// File: rtl/ecpeta_adder_if.sv
// ecpeta_adder_if: operand/result bundle (in_valid, A, B in; out_valid, sum out) with master (driver) and slave (adder) modports
interface ecpeta_adder_if #(parameter int n = 16);
  logic         in_valid;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         out_valid;
  logic [n-1:0] sum;
  modport master (output in_valid, A, B, input out_valid, sum);
  modport slave (input in_valid, A, B, output out_valid, sum);
endinterface

// File: rtl/ecpeta_adder.sv
// ecpeta_adder: registered approximate adder (exact upper n-k bits plus saturating carry-free lower k bits); ports clk, rst, bus.slave (in_valid, A, B -> out_valid, sum)
module ecpeta_adder #(
  parameter int n = 16,
  parameter int k = 6
) (
  input  logic                clk,
  input  logic                rst,
  ecpeta_adder_if.slave       bus
);
  logic [k-1:0] gen;
  logic [k-1:0] sat;
  logic [k-1:0] lo;
  logic [n-k-1:0] hi;
  logic cin;
  assign gen = bus.A[k-1:0] & bus.B[k-1:0];
  for (genvar i = 0; i < k; i++) begin : g_sat
    assign sat[i] = |gen[k-1:i];
  end
  assign lo  = (bus.A[k-1:0] ^ bus.B[k-1:0]) | sat;
  assign cin = gen[k-1];
  assign hi  = bus.A[n-1:k] + bus.B[n-1:k] + (n-k)'(cin);
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.sum <= {hi, lo};
    end
  end
endmodule

// File: tb/tb_ecpeta_adder.sv
// tb_ecpeta_adder: table-driven and sequence checks of ecpeta_adder against hand-computed values and an independent model
module tb_ecpeta_adder;
  localparam int N = 16;
  localparam int K = 6;
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  logic [N-1:0] exp_sum;
  logic exp_ov;
  vec_t vecs [6];
  ecpeta_adder_if #(.n(N)) bus ();
  ecpeta_adder #(.n(N), .k(K)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [N-1:0] ref_f(input logic [N-1:0] a, input logic [N-1:0] b);
    int j;
    int up;
    int lo;
    j = -1;
    for (int i = K - 1; i >= 0; i--)
      if (j < 0 && a[i] && b[i]) j = i;
    lo = 0;
    for (int i = 0; i < K; i++)
      if (i <= j || (a[i] != b[i])) lo = lo + (1 << i);
    up = (int'(a) >> K) + (int'(b) >> K) + ((a[K-1] && b[K-1]) ? 1 : 0);
    return N'((up << K) + lo);
  endfunction
  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask
  task automatic cyc(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 16'h68BF};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[2] = '{16'hAAAA, 16'h5555, 16'hFFFF};
    vecs[3] = '{16'h0F0F, 16'hF0F0, 16'hFFFF};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{16'h1234, 16'h5678, 16'h68BF};
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 16'hFFFF, 16'hFFFF);
      check("reset_sum", bus.sum, 16'h0000);
      check("reset_valid", 16'(bus.out_valid), 16'h0000);
    end
    rst = 1'b0;
    cyc(1'b0, 16'hFFFF, 16'hFFFF);
    check("post_reset_valid", 16'(bus.out_valid), 16'h0000);
    check("post_reset_sum", bus.sum, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_sum", i), bus.sum, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), 16'(bus.out_valid), 16'h0001);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'(i * 16'h1111), 16'hFFFF);
      check("gap_valid", 16'(bus.out_valid), 16'h0000);
      check("gap_hold", bus.sum, 16'h68BF);
    end
    cyc(1'b1, 16'h0001, 16'h0001);
    check("j0_sum", bus.sum, 16'h0001);
    check("j0_valid", 16'(bus.out_valid), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = N'($urandom);
      cyc(1'b1, a, b);
      check("pre_rst_rand", bus.sum, ref_f(a, b));
    end
    rst = 1'b1;
    cyc(1'b1, 16'h1234, 16'h5678);
    check("mid_rst_sum", bus.sum, 16'h0000);
    check("mid_rst_valid", 16'(bus.out_valid), 16'h0000);
    rst = 1'b0;
    cyc(1'b0, 16'hFFFF, 16'h0001);
    check("after_rst_sum", bus.sum, 16'h0000);
    check("after_rst_valid", 16'(bus.out_valid), 16'h0000);
    exp_sum = '0;
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] a, b;
      logic v;
      a = N'($urandom);
      b = (i % 4 == 0) ? a : N'($urandom);
      v = ($urandom_range(0, 3) != 0);
      cyc(v, a, b);
      exp_ov = v;
      if (v) exp_sum = ref_f(a, b);
      check("rand_valid", 16'(bus.out_valid), 16'(exp_ov));
      check("rand_sum", bus.sum, exp_sum);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ecpeta_adder.md
Name: ecpeta_adder

Overview:
- Registered approximate adder: Error-Compensated Partially-Exact Truncated Adder.
- Splits each n-bit operand into an exact upper part (n-k bits) and an approximate lower part (k bits).
- The lower part uses carry-free saturating logic. A single predicted carry from lower bit k-1 compensates the upper part.
- Used in error-tolerant datapaths; one-cycle latency.

Parameters:
- n, 16, operand and sum width in bits. Legal range n >= 3.
- k, 6, width of the approximate lower part. Legal range 1 <= k <= n-1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, A/B are sampled on this clock edge.
- A, input, n, operand A (unsigned).
- B, input, n, operand B (unsigned).
- out_valid, output, 1, sum holds the result for the operands sampled one cycle earlier.
- sum, output, n, approximate sum (unsigned, no carry-out).

Behaviour:
- One clock, clk; synchronous active-high reset rst. Reset is sampled only on the rising edge of clk.
- Reset: sum = 0, out_valid = 0. Reset has priority over in_valid.
- When rst is asserted in the same cycle as in_valid=1, the operands are discarded.
- Latency: 1 cycle.
  - If in_valid=1 at edge t (rst=0), the registered sum holds f(A,B) after edge t and out_valid=1.
  - If in_valid=0 at an edge (rst=0), out_valid goes 0 and sum holds its previous value.
- No backpressure. A new operand pair may be accepted every cycle.
- The result f(A,B) is computed combinationally from the sampled A and B.
- Lower part, bits k-1..0, carry-free, no carry chain:
  - Find the highest index j in [k-1..0] with A[j]&B[j]=1.
  - If j exists: sum[i] = A[i]^B[i] for j < i <= k-1, and sum[i] = 1 for 0 <= i <= j (saturate).
  - If no such j exists: sum[k-1:0] = A[k-1:0] ^ B[k-1:0].
- Compensation carry: cin = A[k-1] & B[k-1].
- Upper part: sum[n-1:k] = (A[n-1:k] + B[n-1:k] + cin) mod 2^(n-k).
  - Exact ripple/any adder is permitted.
  - Upper carry-out is discarded, so the result wraps modulo 2^n.
- Boundary cases:
  - Operands with no overlapping set bits in [k-1:0] give the exact sum (modulo 2^n).
  - All-zero operands give 0.
  - The saturation rule guarantees lower-part error |err| < 2^k. When cin=0, the result never exceeds the exact sum in the lower field.
  - The all-ones lower saturation applies even when exact addition would overflow. For example, FFFF+0001 yields FFFF, not 0000.
- Purely unsigned; no overflow flag.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, A=FFFF, B=FFFF -> sum=0000, out_valid=0 throughout. Deassert rst with in_valid=0 -> out_valid stays 0.
- Compensated saturation (n=16, k=6): A=1234, B=5678, in_valid=1.
  - Lower field saturates to 3F because j=5; cin=1; upper = 72+345+1 = 418.
  - Next cycle: sum=68BF (26815), out_valid=1. Exact sum 68AC is not expected.
- Saturation without carry: A=FFFF, B=0001 -> next cycle sum=FFFF, out_valid=1 (not the wrapped 0000).
- Exact cases, back-to-back on consecutive cycles, each result appearing exactly one cycle after its input:
  - AAAA+5555 -> FFFF.
  - 0F0F+F0F0 -> FFFF.
  - 0000+0000 -> 0000.
  - 1234+5678 -> 68BF (repeatability).
- Valid gaps: after A=1234, B=5678 accepted, drop in_valid for 3 cycles while changing A/B -> out_valid=0 and sum stays 68BF. Then re-raise in_valid with A=0001, B=0001 -> next cycle sum=0001 (j=0 saturation), out_valid=1.
- Reset mid-stream: in_valid=1 every cycle with random operands, assert rst for 1 cycle -> the following cycle shows sum=0000, out_valid=0, and the operands presented during rst never appear. Afterwards compare random traffic against a reference model of f(A,B).
